weight_loader: RTL and testbench
================================

# weight_loader

Write-side front end for the local weight memory. Accepts a burst command (base address, word count), then consumes a valid/ready stream of 16-bit weights and drives the memory's single-word write port (`write_weight_signal`, `weight_addr`, `write_weight_data`) one word per accepted beat. It sits between the bus/DMA weight stream and the weight memory, and signals completion so the conv datapath can begin 48-bit triplet reads.

## Interface

**Parameters**
- `MAX_WEIGHTS`, 8010: memory depth in 16-bit words; bound for command range check.

**Ports**
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: command strobe; sampled only in IDLE.
- `base_addr` input 16: first word address of the burst; sampled with `start`.
- `weight_count` input 16: number of words in the burst; sampled with `start`.
- `in_valid` input 1: stream word valid.
- `in_data` input 16: stream word.
- `in_ready` output 1: stream ready, combinational from state (high only in LOAD).
- `write_weight_signal` output 1: registered write strobe to the memory.
- `weight_addr` output 16: registered write address.
- `write_weight_data` output 16: registered write data.
- `busy` output 1: high in LOAD and DONE.
- `done` output 1: one-cycle pulse when the burst completes.
- `err` output 1: one-cycle pulse when a command is rejected.

## Operation

- **States:** IDLE, LOAD, DONE.
- **IDLE + `start`:**
  - Latch `base_addr` into the base register, `weight_count` into the count register, and clear the index to 0.
  - Reject if `weight_count` is 0, or if `base_addr + weight_count` (17-bit sum) exceeds `MAX_WEIGHTS`. On reject: pulse `err` the next cycle, stay in IDLE, issue no writes.
  - Otherwise go to LOAD.
- **LOAD:**
  - `in_ready` = 1.
  - Each cycle with `in_valid` high is one beat. On each beat, register `write_weight_signal` = 1, `weight_addr` = base + index and `write_weight_data` = `in_data`, then increment the index.
  - On the beat where index == count-1, go to DONE.
  - Cycles without a beat: `write_weight_signal` = 0, and `weight_addr`/`write_weight_data` hold their previous values.
- **DONE:** exactly one cycle, then IDLE. `done` = 1 during this cycle, coincident with the final write strobe.
- **`start` outside IDLE:** ignored; the command inputs are not re-latched.
- **Address arithmetic:** 16-bit; it cannot wrap because of the range check. The last written address is base + count - 1 ≤ `MAX_WEIGHTS` - 1.
- **`in_valid` outside LOAD:** the word is not consumed and no write is issued.
- **`rst` asserted at any time, including mid-burst:**
  - The state machine returns to IDLE.
  - All outputs go to 0 immediately.
  - Any pending write strobe is dropped.
  - Words already written remain in the memory; the memory has its own reset.

## Timing

- **Reset values:** `in_ready` 0, `write_weight_signal` 0, `weight_addr` 0, `write_weight_data` 0, `busy` 0, `done` 0, `err` 0.
- **Command to ready:** `start` sampled at edge E, so `in_ready` is high from E onward (LOAD during the cycle after E).
- **Beat to memory update:** a beat at edge N puts the strobe, address and data on the outputs during cycle N..N+1. The memory captures the word at edge N+1, and it is readable from N+1 onward.
- **Throughput:** one word per cycle with `in_valid` held high. A burst of C words takes C cycles in LOAD plus 1 cycle in DONE.
- **Last beat:** the last beat at edge N gives `done` = 1 and `write_weight_signal` = 1 in the same cycle after N. IDLE is reached at N+1, and `start` can be accepted at N+1 or later.
- **Reject timing:** reject at edge E gives `err` high during the cycle after E; it is back to 0 after E+1.
- **Back-pressure:** none from the memory side. `in_ready` never depends on `in_valid`.

## Test plan

- **Basic burst:** reset, then `start` with base 0 and count 6; stream 0x0011..0x0016 with `in_valid` held high.
  - Required: six consecutive strobes at addresses 0..5 with the matching data.
  - `done` pulses with the 6th strobe.
  - A triplet read at address 1 of the memory then returns 0x0016_0015_0014.
- **Gapped stream:** base 100, count 3, `in_valid` toggling 1,0,0,1,0,1.
  - Required: strobes only in the cycles after beats, at addresses 100, 101, 102.
  - `busy` stays high throughout; `done` pulses with the 3rd strobe.
- **Range reject:**
  - `start` with base 8000 and count 11: one `err` pulse, no strobes, `in_ready` stays 0.
  - `start` with base 8000 and count 10: accepted; the last write goes to address 8009.
- **Zero count and ignored start:**
  - `start` with count 0: one `err` pulse and no writes.
  - A `start` pulse with new base/count mid-burst has no effect on the addresses of the current burst.
- **Reset mid-burst:** base 20, count 9; assert `rst` after 4 beats.
  - Required: all outputs 0 immediately, state IDLE, no further strobes.
  - Addresses 20..23 hold the written data (5th strobe dropped if in flight).
  - A new burst after reset works normally.

Source files
------------

// File: rtl/weight_loader.sv
// weight_loader: write-side front end for the local weight memory.
// Takes a (base, count) burst command and turns each accepted 16-bit
// stream beat into one registered single-word write to the memory.
// Commands that are empty or would run past the end of the memory are
// refused with a one-cycle err pulse.
module weight_loader #(
    parameter int unsigned MAX_WEIGHTS = 8010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [15:0] weight_count,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        write_weight_signal,
    output logic [15:0] weight_addr,
    output logic [15:0] write_weight_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] base_q,  base_d;
    logic [15:0] count_q, count_d;
    logic [15:0] index_q, index_d;
    logic        wr_q,    wr_d;
    logic [15:0] addr_q,  addr_d;
    logic [15:0] data_q,  data_d;
    logic        err_q,   err_d;

    // A command is usable when it is non-empty and its last word
    // (base + count - 1) still lies inside the memory. The sum is taken
    // at 17 bits so a base near 0xFFFF cannot wrap into a false accept.
    function automatic logic cmd_ok(input logic [15:0] b, input logic [15:0] c);
        logic [16:0] sum;
        sum = {1'b0, b} + {1'b0, c};
        return (c != 16'd0) && (sum <= 17'(MAX_WEIGHTS));
    endfunction

    // Next-state, burst bookkeeping and next write-port values.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        index_d = index_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    count_d = weight_count;
                    index_d = 16'd0;
                    if (cmd_ok(base_addr, weight_count)) begin
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    wr_d    = 1'b1;
                    addr_d  = base_q + index_q;
                    data_d  = in_data;
                    index_d = index_q + 16'd1;
                    if (index_q == (count_q - 16'd1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and write-port registers; reset drops any pending strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= 16'd0;
            count_q <= 16'd0;
            index_q <= 16'd0;
            wr_q    <= 1'b0;
            addr_q  <= 16'd0;
            data_q  <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            index_q <= index_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Status outputs decode straight from the state register.
    always_comb begin
        in_ready = (state_q == ST_LOAD);
        busy     = (state_q == ST_LOAD) || (state_q == ST_DONE);
        done     = (state_q == ST_DONE);
    end

    assign write_weight_signal = wr_q;
    assign weight_addr         = addr_q;
    assign write_weight_data   = data_q;
    assign err                 = err_q;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader. A behavioural model predicts,
// per command, whether it is accepted and which (address, word) pairs
// must reach the memory; a shadow memory is filled from the write port.
module tb_weight_loader;

    localparam int MAXW = 8010;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] weight_count;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        write_weight_signal;
    logic [15:0] weight_addr;
    logic [15:0] write_weight_data;
    logic        busy;
    logic        done;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem [MAXW];
    logic [15:0] last_addr;
    logic [15:0] last_data;

    weight_loader #(.MAX_WEIGHTS(MAXW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .base_addr           (base_addr),
        .weight_count        (weight_count),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_ready            (in_ready),
        .write_weight_signal (write_weight_signal),
        .weight_addr         (weight_addr),
        .write_weight_data   (write_weight_data),
        .busy                (busy),
        .done                (done),
        .err                 (err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk48(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model: a strobe visible during a cycle is captured at the next edge.
    task automatic step();
        logic        s;
        logic [15:0] a;
        logic [15:0] d;
        s = write_weight_signal;
        a = weight_addr;
        d = write_weight_data;
        @(posedge clk);
        if (s && (int'(a) < MAXW)) mem[a] = d;
        #1;
    endtask

    function automatic bit accept(input logic [15:0] b, input logic [15:0] c);
        return (c != 16'd0) && ((int'(b) + int'(c)) <= MAXW);
    endfunction

    task automatic check_all_zero(input string tag);
        chk1({tag, "_in_ready"}, in_ready, 1'b0);
        chk1({tag, "_strobe"}, write_weight_signal, 1'b0);
        chk16({tag, "_addr"}, weight_addr, 16'h0000);
        chk16({tag, "_data"}, write_weight_data, 16'h0000);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
    endtask

    // mode 0: random valid/data, 1: valid held with data 0x11+k,
    // 2: valid pattern 1,0,0,1,0,1 then held. stray = cycle of a mid-burst start.
    task automatic burst(input logic [15:0] b, input logic [15:0] c, input int mode, input int stray);
        bit          acc;
        bit          v;
        int          beats;
        int          cyc;
        int          bound;
        logic [15:0] wd;
        bit          gp [6];
        gp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        acc = accept(b, c);
        start        = 1'b1;
        base_addr    = b;
        weight_count = c;
        in_valid     = 1'($urandom_range(0, 1));
        in_data      = 16'($urandom);
        step();
        start        = 1'b0;
        base_addr    = 16'($urandom);
        weight_count = 16'($urandom);
        chk1("cmd_strobe", write_weight_signal, 1'b0);
        if (!acc) begin
            chk1("rej_err", err, 1'b1);
            chk1("rej_in_ready", in_ready, 1'b0);
            chk1("rej_busy", busy, 1'b0);
            step();
            chk1("rej_err_clear", err, 1'b0);
            chk1("rej_no_strobe", write_weight_signal, 1'b0);
            chk1("rej_in_ready2", in_ready, 1'b0);
            in_valid = 1'b0;
            return;
        end
        chk1("acc_in_ready", in_ready, 1'b1);
        chk1("acc_busy", busy, 1'b1);
        chk1("acc_err", err, 1'b0);
        chk1("acc_done", done, 1'b0);
        beats = 0;
        cyc   = 0;
        bound = 8 * int'(c) + 32;
        while ((beats < int'(c)) && (cyc < bound)) begin
            if (mode == 1) v = 1'b1;
            else if (mode == 2) v = (cyc < 6) ? gp[cyc] : 1'b1;
            else v = ($urandom_range(0, 3) != 0);
            wd       = (mode == 1) ? 16'(16'h0011 + beats) : 16'($urandom);
            in_valid = v;
            in_data  = wd;
            if (cyc == stray) begin
                start        = 1'b1;
                base_addr    = 16'($urandom_range(0, 4000));
                weight_count = 16'($urandom_range(1, 20));
            end
            step();
            start = 1'b0;
            if (v) begin
                last_addr = 16'(int'(b) + beats);
                last_data = wd;
                beats++;
            end
            chk1("ld_strobe", write_weight_signal, v);
            chk16("ld_addr", weight_addr, last_addr);
            chk16("ld_data", write_weight_data, last_data);
            chk1("ld_done", done, v && (beats == int'(c)));
            chk1("ld_busy", busy, 1'b1);
            chk1("ld_in_ready", in_ready, beats < int'(c));
            chk1("ld_err", err, 1'b0);
            cyc++;
        end
        chk1("burst_completed_in_budget", beats == int'(c), 1'b1);
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 16'($urandom);
        step();
        chk1("end_strobe", write_weight_signal, 1'b0);
        chk1("end_done", done, 1'b0);
        chk1("end_busy", busy, 1'b0);
        chk1("end_in_ready", in_ready, 1'b0);
        chk16("end_addr_hold", weight_addr, last_addr);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] wd [9];
        logic [47:0] trip;
        logic [15:0] rb;
        logic [15:0] rc;
        for (int i = 0; i < MAXW; i++) mem[i] = 16'h0000;
        rst          = 1'b1;
        start        = 1'b0;
        base_addr    = 16'h0000;
        weight_count = 16'h0000;
        in_valid     = 1'b0;
        in_data      = 16'h0000;
        last_addr    = 16'h0000;
        last_data    = 16'h0000;
        #12;
        check_all_zero("reset");
        step();
        rst = 1'b0;
        step();
        check_all_zero("post_reset");

        // Basic burst and triplet read at triplet address 1 (words 3..5).
        burst(16'd0, 16'd6, 1, -1);
        trip = {mem[5], mem[4], mem[3]};
        chk48("triplet_1", trip, 48'h0016_0015_0014);
        chk16("mem_0", mem[0], 16'h0011);

        // Gapped stream with a stray start in the middle.
        burst(16'd100, 16'd3, 2, 2);

        // Range boundary.
        burst(16'd8000, 16'd11, 0, -1);
        burst(16'd8000, 16'd10, 1, -1);
        chk16("mem_8009", mem[8009], 16'h001a);
        burst(16'd8009, 16'd1, 0, -1);
        burst(16'd8010, 16'd1, 0, -1);

        // Zero count and 17-bit sum cases.
        burst(16'd50, 16'd0, 0, -1);
        burst(16'hffff, 16'd1, 0, -1);
        burst(16'd0, 16'hffff, 0, -1);

        // Reset mid-burst: 4 writes land, the 5th strobe is dropped.
        for (int k = 0; k < 9; k++) wd[k] = 16'($urandom) | 16'h8000;
        start        = 1'b1;
        base_addr    = 16'd20;
        weight_count = 16'd9;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = wd[k];
            step();
        end
        chk1("mid_strobe5", write_weight_signal, 1'b1);
        chk16("mid_addr5", weight_addr, 16'd24);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        step();
        rst      = 1'b0;
        in_valid = 1'b1;
        step();
        chk1("after_rst_strobe", write_weight_signal, 1'b0);
        chk1("after_rst_in_ready", in_ready, 1'b0);
        chk1("after_rst_busy", busy, 1'b0);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) chk16("mid_mem_kept", mem[20 + k], wd[k]);
        chk16("mid_mem_dropped", mem[24], 16'h0000);
        last_addr = 16'h0000;
        last_data = 16'h0000;
        burst(16'd20, 16'd9, 0, -1);

        // Randomized commands around the range boundary and elsewhere.
        for (int n = 0; n < 16; n++) begin
            rc = 16'($urandom_range(0, 12));
            case ($urandom_range(0, 3))
                0: rb = 16'($urandom_range(0, 7990));
                1: rb = 16'(MAXW - int'(rc));
                2: rb = 16'(MAXW - int'(rc) + 1);
                default: rb = 16'($urandom);
            endcase
            burst(rb, rc, 0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 5)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
